// File: rtl/act_out_buffer.sv
// Activation output buffer: captures one f per complete assertion into a circular FIFO and streams layer-framed words.
// Latency: a capture at edge t is visible on m_valid/m_data after edge t; outputs come only from registers.
// Backpressure: m_ready stalls the head word; a capture into a full FIFO without a same-cycle pop is dropped and sets overflow.
// Optional feature: define ACT_CLAMP_EN to saturate stored magnitudes to ONE.
module act_out_buffer #(
    parameter int             WIDTH   = 15,
    parameter int             DEPTH   = 8,
    parameter int             NEURONS = 4,
    parameter logic [WIDTH:0] ONE     = 16'h0400
) (
    input  logic                     clk,
    input  logic                     ext_reset,
    input  logic [WIDTH:0]           f,
    input  logic                     complete,
    input  logic                     clr,
    output logic [WIDTH:0]           m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     layer_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAST_IDX = 8'(NEURONS - 1);
`ifdef ACT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic           last;
        logic [WIDTH:0] dat;
    } entry_t;

    typedef enum logic {ARMED, HOLD} cap_state_e;

    cap_state_e     state_q, state_d;
    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]     idx_q, idx_d;
    logic           overflow_q, overflow_d;
    logic           layer_done_q, layer_done_d;

    logic [AW:0]    occ;
    logic           full;
    logic           head_vld;
    logic           pop;
    logic           capture;
    logic           push;
    logic           drop;
    logic [WIDTH:0] f_store;
    entry_t         head;

    // Occupancy from the extended pointers: the extra MSB disambiguates full from empty.
    always_comb begin
        occ      = wr_ptr_q - rd_ptr_q;
        full     = (occ == (AW+1)'(DEPTH));
        head_vld = (occ != '0);
        head     = mem_q[rd_ptr_q[AW-1:0]];
        pop      = head_vld & m_ready;
        capture  = (state_q == ARMED) & complete & ~clr;
        push     = capture & (~full | pop);
        drop     = capture & full & ~pop;
    end

    always_comb begin
        f_store = f;
        if (CLAMP_EN && (f[WIDTH-1:0] > ONE[WIDTH-1:0])) begin
            f_store = {f[WIDTH], ONE[WIDTH-1:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED:   if (complete)  state_d = HOLD;
            HOLD:    if (!complete) state_d = ARMED;
            default:                state_d = ARMED;
        endcase
        // A clear during an in-flight assertion must not cause a re-capture of it.
        if (clr) begin
            state_d = complete ? HOLD : ARMED;
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        idx_d        = idx_q;
        overflow_d   = overflow_q;
        layer_done_d = pop & head.last;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{last: (idx_q == LAST_IDX), dat: f_store};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Dropped words still consume a neuron slot so framing tracks the neuron sequence.
        if (capture) begin
            idx_d = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            idx_d        = '0;
            overflow_d   = 1'b0;
            layer_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            state_q      <= ARMED;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign m_valid    = head_vld;
    assign m_data     = head_vld ? head.dat : '0;
    assign m_last     = head_vld & head.last;
    assign layer_done = layer_done_q;
    assign count      = occ;
    assign overflow   = overflow_q;

endmodule
